// File: rtl/proj_lif_scheduler.sv
// Sequences an external projection LIF datapath over NEURONS x TIME_STEPS for one sample,
// owning the membrane store and packing spikes. Optional macro: PROJ_LIF_SPIKE_CNT_EN.
module proj_lif_scheduler #(
    parameter int MEM_W      = 20,
    parameter int NEURONS    = 384,
    parameter int TIME_STEPS = 4,
    parameter int SPIKE_W    = 16,
    localparam int N_W = $clog2(NEURONS),
    localparam int T_W = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1,
    localparam int P_W = $clog2(SPIKE_W)
) (
    input  logic               s_clk,
    input  logic               s_rst,
    input  logic               i_start,
    input  logic [MEM_W-1:0]   i_threshold,
    input  logic [MEM_W-1:0]   s_delta_mem,
    input  logic               s_delta_valid,
    output logic               s_delta_ready,
    output logic [MEM_W-1:0]   o_lif_threshold,
    output logic [MEM_W-1:0]   o_lif_delta_mem,
    output logic               o_lif_delta_valid,
    output logic [MEM_W-1:0]   o_lif_pre_mem,
    input  logic               i_lif_spike,
    input  logic               i_lif_valid,
    input  logic [MEM_W-1:0]   i_lif_nxt_mem,
    output logic [SPIKE_W-1:0] o_spike_word,
    output logic               o_spike_valid,
    output logic [T_W-1:0]     o_timestep,
    output logic               o_busy,
`ifdef PROJ_LIF_SPIKE_CNT_EN
    output logic [$clog2(NEURONS+1)-1:0] o_spike_cnt,
    output logic                         o_spike_cnt_valid,
`endif
    output logic               o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [N_W-1:0] N_LAST = N_W'(NEURONS - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIME_STEPS - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(SPIKE_W - 1);

    state_t             state_r;
    state_t             next_s;
    logic [N_W-1:0]     n_cnt_r;
    logic [T_W-1:0]     t_cnt_r;
    logic [N_W-1:0]     wr_addr_r;
    logic [P_W-1:0]     pk_cnt_r;
    logic [SPIKE_W-1:0] pk_word_r;
    logic [SPIKE_W-1:0] pk_next_s;
    logic               hs_s;
    logic               lif_ok_s;
    logic [MEM_W-1:0]   mem_r [NEURONS];

    assign hs_s       = s_delta_ready && s_delta_valid;
    assign lif_ok_s   = i_lif_valid && ((state_r == S_RUN) || (state_r == S_DRAIN));
    assign o_timestep = t_cnt_r;

    // State register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE:  if (i_start) next_s = S_CLEAR; else next_s = S_IDLE;
            S_CLEAR: if (n_cnt_r == N_LAST) next_s = S_RUN; else next_s = S_CLEAR;
            S_RUN:   if (hs_s && (n_cnt_r == N_LAST) && (t_cnt_r == T_LAST)) next_s = S_DRAIN;
                     else next_s = S_RUN;
            S_DRAIN: next_s = S_DONE;
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // State-decoded outputs; the LIF request is a same-cycle pass-through of the handshake
    always_comb begin
        s_delta_ready     = 1'b0;
        o_lif_delta_valid = 1'b0;
        o_lif_delta_mem   = {MEM_W{1'b0}};
        o_lif_pre_mem     = {MEM_W{1'b0}};
        o_busy            = (state_r != S_IDLE);
        if (state_r == S_RUN) begin
            s_delta_ready = 1'b1;
            if (s_delta_valid) begin
                o_lif_delta_valid = 1'b1;
                o_lif_delta_mem   = s_delta_mem;
                o_lif_pre_mem     = mem_r[n_cnt_r];
            end else begin
                o_lif_delta_valid = 1'b0;
            end
        end else begin
            s_delta_ready = 1'b0;
        end
    end

    // Neuron/timestep counters, write-back address, threshold latch and done pulse
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            n_cnt_r         <= {N_W{1'b0}};
            t_cnt_r         <= {T_W{1'b0}};
            wr_addr_r       <= {N_W{1'b0}};
            o_lif_threshold <= {MEM_W{1'b0}};
            o_done          <= 1'b0;
        end else begin
            o_done <= (state_r == S_DRAIN);
            case (state_r)
                S_IDLE: begin
                    n_cnt_r <= {N_W{1'b0}};
                    t_cnt_r <= {T_W{1'b0}};
                    if (i_start) o_lif_threshold <= i_threshold;
                end
                S_CLEAR: n_cnt_r <= (n_cnt_r == N_LAST) ? {N_W{1'b0}} : n_cnt_r + N_W'(1);
                S_RUN: begin
                    if (hs_s) begin
                        wr_addr_r <= n_cnt_r;
                        if (n_cnt_r == N_LAST) begin
                            n_cnt_r <= {N_W{1'b0}};
                            // The final wrap leaves t_cnt on the last step until DONE
                            if (t_cnt_r != T_LAST) t_cnt_r <= t_cnt_r + T_W'(1);
                        end else begin
                            n_cnt_r <= n_cnt_r + N_W'(1);
                        end
                    end
                end
                S_DONE:  t_cnt_r <= {T_W{1'b0}};
                default: ;
            endcase
        end
    end

    // Membrane store: zeroed during CLEAR, LIF write-back lags the read by one cycle
    always_ff @(posedge s_clk) begin
        if (state_r == S_CLEAR) begin
            mem_r[n_cnt_r] <= {MEM_W{1'b0}};
        end else if (lif_ok_s) begin
            mem_r[wr_addr_r] <= i_lif_nxt_mem;
        end
    end

    // Pack register with the incoming spike merged in
    always_comb begin
        pk_next_s           = pk_word_r;
        pk_next_s[pk_cnt_r] = i_lif_spike;
    end

    // Spike word packing and emission
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            pk_cnt_r      <= {P_W{1'b0}};
            pk_word_r     <= {SPIKE_W{1'b0}};
            o_spike_word  <= {SPIKE_W{1'b0}};
            o_spike_valid <= 1'b0;
        end else begin
            o_spike_valid <= 1'b0;
            if (state_r == S_IDLE) begin
                pk_cnt_r <= {P_W{1'b0}};
            end else if (lif_ok_s) begin
                pk_word_r <= pk_next_s;
                if (pk_cnt_r == P_LAST) begin
                    o_spike_word  <= pk_next_s;
                    o_spike_valid <= 1'b1;
                    pk_cnt_r      <= {P_W{1'b0}};
                end else begin
                    pk_cnt_r <= pk_cnt_r + P_W'(1);
                end
            end
        end
    end

`ifdef PROJ_LIF_SPIKE_CNT_EN
    localparam int C_W = $clog2(NEURONS + 1);
    logic [C_W-1:0] spk_cnt_r;
    logic [C_W-1:0] spk_sum_s;

    assign spk_sum_s = spk_cnt_r + {{(C_W-1){1'b0}}, i_lif_spike};

    // Per-timestep spike count, reported with the last neuron's result
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            spk_cnt_r         <= {C_W{1'b0}};
            o_spike_cnt       <= {C_W{1'b0}};
            o_spike_cnt_valid <= 1'b0;
        end else begin
            o_spike_cnt_valid <= 1'b0;
            if (state_r == S_IDLE) begin
                spk_cnt_r <= {C_W{1'b0}};
            end else if (lif_ok_s) begin
                if (wr_addr_r == N_LAST) begin
                    o_spike_cnt       <= spk_sum_s;
                    o_spike_cnt_valid <= 1'b1;
                    spk_cnt_r         <= {C_W{1'b0}};
                end else begin
                    spk_cnt_r <= spk_sum_s;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_proj_lif_scheduler.sv
// Self-checking bench for proj_lif_scheduler with a behavioural LIF datapath attached.
module tb_proj_lif_scheduler;
    localparam int MEM_W = 20;
    localparam int N     = 4;
    localparam int TS    = 2;
    localparam int SW    = 2;
    localparam int NV    = N * TS;
    localparam int NWD   = NV / SW;

    logic             s_clk = 1'b0;
    logic             s_rst;
    logic             i_start;
    logic [MEM_W-1:0] i_threshold;
    logic [MEM_W-1:0] s_delta_mem;
    logic             s_delta_valid;
    logic             s_delta_ready;
    logic [MEM_W-1:0] o_lif_threshold;
    logic [MEM_W-1:0] o_lif_delta_mem;
    logic             o_lif_delta_valid;
    logic [MEM_W-1:0] o_lif_pre_mem;
    logic             i_lif_spike;
    logic             i_lif_valid;
    logic [MEM_W-1:0] i_lif_nxt_mem;
    logic [SW-1:0]    o_spike_word;
    logic             o_spike_valid;
    logic [0:0]       o_timestep;
    logic             o_busy;
    logic             o_done;
`ifdef PROJ_LIF_SPIKE_CNT_EN
    logic [2:0]       o_spike_cnt;
    logic             o_spike_cnt_valid;
`endif

    proj_lif_scheduler #(.MEM_W(MEM_W), .NEURONS(N), .TIME_STEPS(TS), .SPIKE_W(SW)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .i_threshold(i_threshold),
        .s_delta_mem(s_delta_mem), .s_delta_valid(s_delta_valid), .s_delta_ready(s_delta_ready),
        .o_lif_threshold(o_lif_threshold), .o_lif_delta_mem(o_lif_delta_mem),
        .o_lif_delta_valid(o_lif_delta_valid), .o_lif_pre_mem(o_lif_pre_mem),
        .i_lif_spike(i_lif_spike), .i_lif_valid(i_lif_valid), .i_lif_nxt_mem(i_lif_nxt_mem),
        .o_spike_word(o_spike_word), .o_spike_valid(o_spike_valid), .o_timestep(o_timestep),
        .o_busy(o_busy),
`ifdef PROJ_LIF_SPIKE_CNT_EN
        .o_spike_cnt(o_spike_cnt), .o_spike_cnt_valid(o_spike_cnt_valid),
`endif
        .o_done(o_done)
    );

    always #5 s_clk = ~s_clk;

    // Behavioural LIF: halve (pre + delta), fire at threshold and reset to zero
    logic signed [MEM_W-1:0] lif_half;
    logic                    lif_fire;
    assign lif_half = ($signed(o_lif_pre_mem) + $signed(o_lif_delta_mem)) >>> 1;
    assign lif_fire = (lif_half >= $signed(o_lif_threshold));

    always @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            i_lif_valid   <= 1'b0;
            i_lif_spike   <= 1'b0;
            i_lif_nxt_mem <= '0;
        end else begin
            i_lif_valid   <= o_lif_delta_valid;
            i_lif_spike   <= o_lif_delta_valid && lif_fire;
            i_lif_nxt_mem <= lif_fire ? '0 : lif_half;
        end
    end

    // Output monitor, sampled mid-cycle
    logic signed [31:0] q_pre[$];
    int q_ts[$];
    int q_word[$];
    int q_cnt[$];
    int n_done   = 0;
    int done_spk = 0;
    always @(negedge s_clk) begin
        if (!s_rst) begin
            if (o_lif_delta_valid) begin
                q_pre.push_back($signed(o_lif_pre_mem));
                q_ts.push_back(int'(o_timestep));
            end
            if (o_spike_valid) q_word.push_back(int'(o_spike_word));
            if (o_done) begin
                n_done++;
                if (o_spike_valid) done_spk++;
            end
`ifdef PROJ_LIF_SPIKE_CNT_EN
            if (o_spike_cnt_valid) q_cnt.push_back(int'(o_spike_cnt));
`endif
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: per-neuron membrane over timesteps, straight from the LIF rules
    int d[NV];
    int thr;
    int exp_pre[NV];
    int exp_word[NWD];
    int exp_cnt[TS];

    task automatic build_model();
        int m[N];
        int v;
        int sp;
        for (int n = 0; n < N; n++) m[n] = 0;
        for (int w = 0; w < NWD; w++) exp_word[w] = 0;
        for (int t = 0; t < TS; t++) exp_cnt[t] = 0;
        for (int t = 0; t < TS; t++) begin
            for (int n = 0; n < N; n++) begin
                exp_pre[t*N+n] = m[n];
                v  = (m[n] + d[t*N+n]) >>> 1;
                sp = (v >= thr) ? 1 : 0;
                m[n] = (sp != 0) ? 0 : v;
                exp_word[(t*N+n)/SW] += sp << ((t*N+n) % SW);
                exp_cnt[t] += sp;
            end
        end
    endtask

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic start_sample();
        i_threshold = MEM_W'(thr);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_threshold = MEM_W'($urandom_range(1000));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("clear_busy[%0d]", i), o_busy, 1);
            chk($sformatf("clear_ready[%0d]", i), s_delta_ready, 0);
            step();
        end
        chk("run_ready", s_delta_ready, 1);
        chk("threshold_latched", o_lif_threshold, thr);
    endtask

    task automatic feed(input int first, input int last, input bit stall);
        bit took;
        int guard;
        for (int i = first; i <= last; i++) begin
            took  = 1'b0;
            guard = 0;
            while (!took && guard < 50) begin
                s_delta_valid = stall ? ($urandom_range(2) != 0) : 1'b1;
                s_delta_mem   = s_delta_valid ? MEM_W'(d[i]) : MEM_W'($urandom);
                took = s_delta_valid && s_delta_ready;
                step();
                guard++;
            end
            if (!took) chk($sformatf("feed_timeout[%0d]", i), 0, 1);
        end
        s_delta_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!o_done && g < 20) begin
            step();
            g++;
        end
        chk("done_seen", o_done, 1);
        step();
        chk("idle_busy", o_busy, 0);
        chk("idle_timestep", o_timestep, 0);
        chk("done_width", o_done, 0);
    endtask

    task automatic run_and_check(input string lbl, input bit stall);
        int bp, bw, bc, nd0, ds0;
        bp = q_pre.size(); bw = q_word.size(); bc = q_cnt.size();
        nd0 = n_done; ds0 = done_spk;
        build_model();
        start_sample();
        feed(0, NV - 1, stall);
        wait_done();
        chk({lbl, "_pre_count"}, q_pre.size() - bp, NV);
        if (q_pre.size() - bp == NV) begin
            for (int i = 0; i < NV; i++) begin
                chk($sformatf("%s_pre_mem[%0d]", lbl, i), q_pre[bp+i], exp_pre[i]);
                chk($sformatf("%s_timestep[%0d]", lbl, i), q_ts[bp+i], i / N);
            end
        end
        chk({lbl, "_word_count"}, q_word.size() - bw, NWD);
        if (q_word.size() - bw == NWD) begin
            for (int w = 0; w < NWD; w++)
                chk($sformatf("%s_word[%0d]", lbl, w), q_word[bw+w], exp_word[w]);
        end
        chk({lbl, "_done_pulses"}, n_done - nd0, 1);
        chk({lbl, "_done_with_last_word"}, done_spk - ds0, 1);
`ifdef PROJ_LIF_SPIKE_CNT_EN
        chk({lbl, "_cnt_count"}, q_cnt.size() - bc, TS);
        if (q_cnt.size() - bc == TS) begin
            for (int t = 0; t < TS; t++)
                chk($sformatf("%s_spike_cnt[%0d]", lbl, t), q_cnt[bc+t], exp_cnt[t]);
        end
`else
        chk({lbl, "_cnt_absent"}, q_cnt.size() - bc, 0);
`endif
    endtask

    task automatic check_reset_outputs(input string lbl);
        chk({lbl, "_busy"}, o_busy, 0);
        chk({lbl, "_ready"}, s_delta_ready, 0);
        chk({lbl, "_spike_valid"}, o_spike_valid, 0);
        chk({lbl, "_spike_word"}, o_spike_word, 0);
        chk({lbl, "_done"}, o_done, 0);
        chk({lbl, "_threshold"}, o_lif_threshold, 0);
        chk({lbl, "_timestep"}, o_timestep, 0);
        chk({lbl, "_lif_valid"}, o_lif_delta_valid, 0);
        chk({lbl, "_lif_pre"}, o_lif_pre_mem, 0);
    endtask

    task automatic load_directed();
        d[0] = 30; d[1] = 4;  d[2] = -8; d[3] = 20;
        d[4] = 20; d[5] = 20; d[6] = 20; d[7] = 0;
        thr = 10;
    endtask

    initial begin
        s_rst = 1'b1;
        i_start = 1'b0;
        i_threshold = '0;
        s_delta_mem = '0;
        s_delta_valid = 1'b0;
        #12;
        check_reset_outputs("reset");
        step();
        s_rst = 1'b0;
        step();

        load_directed();
        run_and_check("clean", 1'b0);
        run_and_check("stall", 1'b1);

        // Abort in the middle of timestep 1
        build_model();
        start_sample();
        feed(0, N + 1, 1'b0);
        s_rst = 1'b1;
        #2;
        check_reset_outputs("midreset");
        step();
        s_rst = 1'b0;
        step();
        run_and_check("rerun", 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NV; i++) d[i] = int'($urandom_range(60)) - 30;
            thr = int'($urandom_range(19)) + 1;
            run_and_check($sformatf("rand%0d", r), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
